// File: rtl/apb_uart_pkg.sv
// Shared register map, bit positions and TX drain FSM states for the APB UART FIFO bridge.
package apb_uart_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STAT   = 3'd1;
    localparam logic [2:0] ADDR_TXDATA = 3'd2;
    localparam logic [2:0] ADDR_RXDATA = 3'd3;
    localparam logic [2:0] ADDR_LEVEL  = 3'd4;
    localparam logic [2:0] ADDR_IRQEN  = 3'd5;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_TX_FLUSH = 2;
    localparam int CTRL_RX_FLUSH = 3;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_TX_BUSY  = 4;
    localparam int STAT_RX_OVF   = 5;
    localparam int STAT_RX_PERR  = 6;

    localparam int IRQ_W = 5;

    localparam logic [31:0] RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head, flush priority and simultaneous push/pop when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart_fifo_bridge.sv
// APB3 slave buffering characters between the bus and external UART TX/RX engines.
module apb_uart_fifo_bridge #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [31:0]       PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rx_err,
    output logic              irq
);

    import apb_uart_pkg::*;

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic              access, wr, rd, mapped;
    logic [2:0]        addr;
    logic [31:0]       rd_data;
    logic              tx_en, rx_en, rx_ovf, rx_perr, tx_done_pend;
    logic [IRQ_W-1:0]  irq_en;
    logic [IRQ_W-1:0]  irq_src;
    logic              tx_flush, rx_flush, tx_push, tx_pop, rx_push, rx_pop;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [TX_CW-1:0]  tx_count;
    logic [RX_CW-1:0]  rx_count;
    logic              wr_ctrl, wr_stat, wr_irqen;
    logic              rx_ovf_set, rx_perr_set, tx_done_set;
    tx_state_t         state;
    logic              unused_bits;

    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

    assign access = PSEL & PENABLE;
    assign wr     = access & PWRITE;
    assign rd     = access & ~PWRITE;
    assign addr   = PADDR[4:2];
    assign PREADY = access;

    assign wr_ctrl  = wr & (addr == ADDR_CTRL);
    assign wr_stat  = wr & (addr == ADDR_STAT);
    assign wr_irqen = wr & (addr == ADDR_IRQEN);

    // Flush bits act only on the write cycle; nothing stores them.
    assign tx_flush = wr_ctrl & PWDATA[CTRL_TX_FLUSH];
    assign rx_flush = wr_ctrl & PWDATA[CTRL_RX_FLUSH];
    assign tx_push  = wr & (addr == ADDR_TXDATA);
    assign tx_pop   = (state == TX_LOAD);
    assign rx_pop   = rd & (addr == ADDR_RXDATA);
    assign rx_push  = rx_done & rx_en;

    assign rx_ovf_set  = rx_push & rx_full & ~rx_pop;
    assign rx_perr_set = rx_push & rx_err;
    assign tx_done_set = (state == TX_WAIT) & tx_done;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(PCLK), .arst_n(PRESETn), .flush(tx_flush), .push(tx_push), .wdata(PWDATA[DATA_W-1:0]),
        .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(PCLK), .arst_n(PRESETn), .flush(rx_flush), .push(rx_push), .wdata(rx_data),
        .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        rd_data = '0;
        mapped  = 1'b1;
        case (addr)
            ADDR_CTRL: begin
                rd_data[CTRL_TX_EN] = tx_en;
                rd_data[CTRL_RX_EN] = rx_en;
            end
            ADDR_STAT: begin
                rd_data[STAT_TX_EMPTY] = tx_empty;
                rd_data[STAT_TX_FULL]  = tx_full;
                rd_data[STAT_RX_EMPTY] = rx_empty;
                rd_data[STAT_RX_FULL]  = rx_full;
                rd_data[STAT_TX_BUSY]  = (state != TX_IDLE);
                rd_data[STAT_RX_OVF]   = rx_ovf;
                rd_data[STAT_RX_PERR]  = rx_perr;
            end
            ADDR_TXDATA: rd_data = '0;
            ADDR_RXDATA: if (!rx_empty) rd_data[DATA_W-1:0] = rx_head;
            ADDR_LEVEL: begin
                rd_data[TX_CW-1:0]   = tx_count;
                rd_data[16 +: RX_CW] = rx_count;
            end
            ADDR_IRQEN: rd_data[IRQ_W-1:0] = irq_en;
            default: begin
                rd_data = RDATA_DEFAULT;
                mapped  = 1'b0;
            end
        endcase
    end

    assign PRDATA  = rd ? rd_data : '0;
    assign PSLVERR = access & (~mapped
                             | (PWRITE & (addr == ADDR_TXDATA) & tx_full & ~tx_pop)
                             | (~PWRITE & (addr == ADDR_RXDATA) & rx_empty));

    assign irq_src = {tx_done_pend, rx_perr, rx_ovf, ~rx_empty, tx_empty};

    // Sticky flags: a set event in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_en        <= 1'b0;
            rx_en        <= 1'b0;
            irq_en       <= '0;
            rx_ovf       <= 1'b0;
            rx_perr      <= 1'b0;
            tx_done_pend <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                tx_en <= PWDATA[CTRL_TX_EN];
                rx_en <= PWDATA[CTRL_RX_EN];
            end
            if (wr_irqen) irq_en <= PWDATA[IRQ_W-1:0];
            if (rx_ovf_set)                             rx_ovf <= 1'b1;
            else if (wr_stat && PWDATA[STAT_RX_OVF])    rx_ovf <= 1'b0;
            if (rx_perr_set)                            rx_perr <= 1'b1;
            else if (wr_stat && PWDATA[STAT_RX_PERR])   rx_perr <= 1'b0;
            if (tx_done_set)                            tx_done_pend <= 1'b1;
            else if (wr_stat && PWDATA[STAT_TX_BUSY])   tx_done_pend <= 1'b0;
            irq <= |(irq_en & irq_src);
        end
    end

    // A flush landing on the IDLE->LOAD edge leaves LOAD with nothing to send.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= TX_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                TX_IDLE: if (tx_en && !tx_empty && !tx_busy) state <= TX_LOAD;
                TX_LOAD: begin
                    if (tx_empty) begin
                        state <= TX_IDLE;
                    end else begin
                        tx_data  <= tx_head;
                        tx_start <= 1'b1;
                        state    <= TX_WAIT;
                    end
                end
                TX_WAIT: if (tx_done) state <= TX_IDLE;
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo_bridge.sv
// Scoreboard bench: APB and TX expectations are queued by stimulus and checked by monitors.
module tb_apb_uart_fifo_bridge;

    localparam int DATA_W = 8;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic [31:0]       PADDR;
    logic              PSEL, PENABLE, PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy, tx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done, rx_err;
    logic              irq;

    typedef struct packed {
        logic        is_read;
        logic        err;
        logic [31:0] data;
    } apb_exp_t;

    apb_exp_t          exp_apb[$];
    string             exp_name[$];
    logic [DATA_W-1:0] exp_tx[$];
    int                n_pass = 0;
    int                n_total = 0;
    bit                model_en = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_uart_fifo_bridge #(.DATA_W(DATA_W), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // APB monitor: every access phase consumes one queued expectation.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (exp_apb.size() == 0) begin
                n_total++;
                $display("FAIL apb_unexpected: transfer at addr 0x%08h with no expectation", PADDR);
            end else begin
                apb_exp_t e;
                string    nm;
                e  = exp_apb.pop_front();
                nm = exp_name.pop_front();
                check({nm, "_pready"}, {31'd0, PREADY}, 32'd1);
                check({nm, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, e.err});
                if (e.is_read) check(nm, PRDATA, e.data);
            end
        end
    end

    // TX monitor: each tx_start must carry the next queued character.
    always @(negedge PCLK) begin
        if (PRESETn === 1'b1 && tx_start === 1'b1) begin
            if (exp_tx.size() == 0) begin
                n_total++;
                $display("FAIL tx_start_unexpected: tx_data 0x%02h, expected no pulse", tx_data);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
        end
    end

    // Transmitter model: busy after tx_start, tx_done pulse 10 cycles later.
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge PCLK);
            if (tx_start === 1'b1 && model_en) begin
                tx_busy = 1'b1;
                repeat (10) @(posedge PCLK);
                #1;
                tx_busy = 1'b0;
                tx_done = 1'b1;
                @(posedge PCLK);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input logic exp_err, input string name);
        apb_exp_t e;
        @(posedge PCLK);
        #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        e.is_read = ~wr;
        e.err     = exp_err;
        e.data    = exp_rd;
        exp_apb.push_back(e);
        exp_name.push_back(name);
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] d, input logic err, input string name);
        apb_xfer(1'b1, addr, d, 32'd0, err, name);
    endtask

    task automatic apb_rd(input logic [31:0] addr, input logic [31:0] exp, input logic err, input string name);
        apb_xfer(1'b0, addr, 32'd0, exp, err, name);
    endtask

    task automatic rx_pulse(input logic [DATA_W-1:0] d, input logic err);
        @(posedge PCLK);
        #1;
        rx_data = d; rx_done = 1'b1; rx_err = err;
        @(posedge PCLK);
        #1;
        rx_done = 1'b0; rx_err = 1'b0;
    endtask

    task automatic wait_tx_drained(input int budget);
        int n = 0;
        while (exp_tx.size() != 0 && n < budget) begin
            @(posedge PCLK);
            n++;
        end
        n_total++;
        if (exp_tx.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL tx_drain_timeout: %0d characters pending, expected 0", exp_tx.size());
            exp_tx.delete();
        end
    endtask

    initial begin
        PRESETn = 1'b0;
        PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
        rx_data = '0; rx_done = 1'b0; rx_err = 1'b0;

        // Reset values
        #2;
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd0);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        apb_rd(32'h04, 32'h0000_0005, 1'b0, "stat_after_reset");
        apb_rd(32'h10, 32'h0000_0000, 1'b0, "level_after_reset");
        check("irq_after_reset", {31'd0, irq}, 32'd0);

        // TX path: queue three characters, then enable draining
        apb_wr(32'h08, 32'h41, 1'b0, "txdata_41");
        apb_wr(32'h08, 32'h42, 1'b0, "txdata_42");
        apb_wr(32'h08, 32'h43, 1'b0, "txdata_43");
        apb_rd(32'h10, 32'h0000_0003, 1'b0, "level_tx3");
        exp_tx.push_back(8'h41);
        exp_tx.push_back(8'h42);
        exp_tx.push_back(8'h43);
        apb_wr(32'h00, 32'h1, 1'b0, "ctrl_tx_en");
        wait_tx_drained(200);
        repeat (15) @(posedge PCLK);
        apb_rd(32'h10, 32'h0000_0000, 1'b0, "level_tx_drained");
        apb_rd(32'h04, 32'h0000_0005, 1'b0, "stat_tx_drained");

        // TX overfill with draining disabled
        apb_wr(32'h00, 32'h0, 1'b0, "ctrl_off");
        for (int i = 0; i < 16; i++) apb_wr(32'h08, 32'(i), 1'b0, "txdata_fill");
        apb_wr(32'h08, 32'h99, 1'b1, "txdata_overfill");
        apb_rd(32'h10, 32'h0000_0010, 1'b0, "level_tx_full");
        apb_rd(32'h04, 32'h0000_0006, 1'b0, "stat_tx_full");
        apb_wr(32'h00, 32'h4, 1'b0, "ctrl_tx_flush");
        apb_rd(32'h00, 32'h0000_0000, 1'b0, "ctrl_flush_selfclear");
        apb_rd(32'h10, 32'h0000_0000, 1'b0, "level_tx_flushed");

        // RX fill past capacity, then drain by reads
        apb_wr(32'h00, 32'h2, 1'b0, "ctrl_rx_en");
        for (int i = 0; i < 17; i++) rx_pulse(DATA_W'(i), 1'b0);
        apb_rd(32'h04, 32'h0000_0029, 1'b0, "stat_rx_ovf");
        apb_rd(32'h10, 32'h0010_0000, 1'b0, "level_rx_full");
        for (int i = 0; i < 16; i++) apb_rd(32'h0C, 32'(i), 1'b0, "rxdata_pop");
        apb_rd(32'h0C, 32'h0000_0000, 1'b1, "rxdata_empty");

        // Overflow interrupt and its W1C
        apb_wr(32'h04, 32'h20, 1'b0, "stat_w1c_ovf");
        apb_rd(32'h04, 32'h0000_0005, 1'b0, "stat_ovf_cleared");
        apb_wr(32'h14, 32'h4, 1'b0, "irqen_ovf");
        @(posedge PCLK);
        #1;
        check("irq_before_ovf", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 17; i++) rx_pulse(DATA_W'(8'h10 + i), 1'b0);
        check("irq_same_cycle_ovf", {31'd0, irq}, 32'd0);
        @(posedge PCLK);
        #1;
        check("irq_after_ovf", {31'd0, irq}, 32'd1);
        apb_wr(32'h04, 32'h20, 1'b0, "stat_w1c_ovf2");
        @(posedge PCLK);
        #1;
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        apb_wr(32'h00, 32'hA, 1'b0, "ctrl_rx_flush");
        apb_rd(32'h00, 32'h0000_0002, 1'b0, "ctrl_after_rx_flush");
        rx_pulse(8'h55, 1'b1);
        apb_rd(32'h04, 32'h0000_0041, 1'b0, "stat_rx_perr");
        apb_rd(32'h0C, 32'h0000_0055, 1'b0, "rxdata_perr_char");
        apb_wr(32'h04, 32'h40, 1'b0, "stat_w1c_perr");
        apb_rd(32'h04, 32'h0000_0005, 1'b0, "stat_perr_cleared");

        // Address decode
        apb_rd(32'h18, 32'hDEAD_BEEF, 1'b1, "unmapped_read");
        apb_wr(32'h1C, 32'h1F, 1'b1, "unmapped_write");
        apb_rd(32'h0000_0117, 32'h0000_0004, 1'b0, "irqen_alias");

        // Reset while a character is in flight
        apb_wr(32'h14, 32'h10, 1'b0, "irqen_txdone");
        @(posedge PCLK);
        #1;
        check("irq_tx_done_pend", {31'd0, irq}, 32'd1);
        model_en = 1'b0;
        apb_wr(32'h08, 32'h5A, 1'b0, "txdata_5a");
        apb_wr(32'h08, 32'h5B, 1'b0, "txdata_5b");
        exp_tx.push_back(8'h5A);
        apb_wr(32'h00, 32'h1, 1'b0, "ctrl_tx_en2");
        wait_tx_drained(50);
        repeat (3) @(posedge PCLK);
        apb_rd(32'h04, 32'h0000_0014, 1'b0, "stat_tx_wait");
        check("tx_data_in_wait", {24'd0, tx_data}, 32'h0000_005A);
        @(posedge PCLK);
        #3;
        PRESETn = 1'b0;
        #1;
        check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_prdata", PRDATA, 32'd0);
        check("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        model_en = 1'b1;
        apb_rd(32'h10, 32'h0000_0000, 1'b0, "level_after_midrst");
        apb_rd(32'h04, 32'h0000_0005, 1'b0, "stat_after_midrst");
        check("irq_after_midrst", {31'd0, irq}, 32'd0);
        repeat (20) @(posedge PCLK);

        check("apb_queue_empty", 32'(exp_apb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
